// File: rtl/vlsu_pkg.sv
// Shared constants and types for the strided vector load/store unit.
package vlsu_pkg;

    localparam int WORD_W        = 32;
    localparam int DEFAULT_LANES = 4;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } vlsu_state_t;

    // Width of a lane index; a single-lane build still needs one bit.
    function automatic int lane_bits(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/vector_lsu_if.sv
// Request/response channel between a vector issuer and the load/store unit.
interface vector_lsu_if #(
    parameter int LANES  = vlsu_pkg::DEFAULT_LANES,
    parameter int WORD_W = vlsu_pkg::WORD_W
);
    logic                      req_valid;
    logic                      req_ready;
    logic                      req_store;
    logic [31:0]               req_base;
    logic [15:0]               req_stride;
    logic [LANES*WORD_W-1:0]   req_wdata;
    logic                      resp_valid;
    logic [LANES*WORD_W-1:0]   resp_rdata;
    logic                      busy;

    modport master (
        output req_valid, req_store, req_base, req_stride, req_wdata,
        input  req_ready, resp_valid, resp_rdata, busy
    );

    modport slave (
        input  req_valid, req_store, req_base, req_stride, req_wdata,
        output req_ready, resp_valid, resp_rdata, busy
    );
endinterface

// File: rtl/vlsu_agu.sv
// Address generator: running byte-address accumulator plus lane counter.
module vlsu_agu
    import vlsu_pkg::*;
#(
    parameter  int LANES  = DEFAULT_LANES,
    localparam int LANE_W = lane_bits(LANES)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              step,
    input  logic [31:0]       base,
    input  logic [15:0]       stride,
    output logic [31:0]       address,
    output logic [LANE_W-1:0] lane,
    output logic              last
);

    logic [31:0]       acc_reg;
    logic [31:0]       inc_reg;
    logic [LANE_W-1:0] lane_reg;

    // Word stride is sign-extended and scaled to bytes once, at request time.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_reg  <= '0;
            inc_reg  <= '0;
            lane_reg <= '0;
        end else if (start) begin
            acc_reg  <= base;
            inc_reg  <= {{14{stride[15]}}, stride, 2'b00};
            lane_reg <= '0;
        end else if (step) begin
            acc_reg  <= acc_reg + inc_reg;
            lane_reg <= lane_reg + 1'b1;
        end
    end

    assign address = acc_reg;
    assign lane    = lane_reg;
    assign last    = (lane_reg == LANE_W'(LANES - 1));

endmodule

// File: rtl/vector_lsu.sv
// Strided vector load/store unit: one memory word per cycle, LANES lanes per request.
module vector_lsu
    import vlsu_pkg::*;
#(
    parameter int LANES  = DEFAULT_LANES,
    parameter int WORD_W = vlsu_pkg::WORD_W
) (
    input  logic              clk,
    input  logic              reset,
    vector_lsu_if.slave       lsu,
    output logic              mem_we,
    output logic [31:0]       mem_address,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata
);

    localparam int LANE_W = lane_bits(LANES);

    vlsu_state_t             state_reg;
    vlsu_state_t             state_next;
    logic                    store_reg;
    logic                    accept;
    logic                    in_access;
    logic [31:0]             agu_address;
    logic [LANE_W-1:0]       lane;
    logic                    last;
    logic [LANES*WORD_W-1:0] wdata_flat;

    assign accept    = (state_reg == IDLE) && lsu.req_valid;
    assign in_access = (state_reg == ACCESS);

    vlsu_agu #(.LANES(LANES)) u_agu (
        .clk     (clk),
        .reset   (reset),
        .start   (accept),
        .step    (in_access),
        .base    (lsu.req_base),
        .stride  (lsu.req_stride),
        .address (agu_address),
        .lane    (lane),
        .last    (last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            store_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                store_reg <= lsu.req_store;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (lsu.req_valid) state_next = ACCESS;
            ACCESS:  if (last)          state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Per-lane store buffer and load result; a store never touches the result lanes.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [WORD_W-1:0] wdata_lane_reg;
        logic [WORD_W-1:0] rdata_lane_reg;

        always_ff @(posedge clk) begin
            if (reset) begin
                wdata_lane_reg <= '0;
                rdata_lane_reg <= '0;
            end else begin
                if (accept) begin
                    wdata_lane_reg <= lsu.req_wdata[gi*WORD_W +: WORD_W];
                end
                if (in_access && !store_reg && (lane == LANE_W'(gi))) begin
                    rdata_lane_reg <= mem_rdata;
                end
            end
        end

        assign wdata_flat[gi*WORD_W +: WORD_W]     = wdata_lane_reg;
        assign lsu.resp_rdata[gi*WORD_W +: WORD_W] = rdata_lane_reg;
    end

    assign lsu.req_ready  = (state_reg == IDLE);
    assign lsu.busy       = (state_reg != IDLE);
    assign lsu.resp_valid = (state_reg == DONE);

    assign mem_we      = in_access && store_reg;
    assign mem_address = in_access ? {agu_address[31:2], 2'b00} : '0;
    assign mem_wdata   = (in_access && store_reg) ? wdata_flat[lane*WORD_W +: WORD_W] : '0;

endmodule

// File: tb/tb_vector_lsu.sv
// Directed bench for vector_lsu: table of vector requests plus reset and busy-ignore sequences.
module tb_vector_lsu;
    import vlsu_pkg::*;

    localparam int L = 4;

    typedef struct packed {
        logic             store;
        logic [31:0]      base;
        logic [15:0]      stride;
        logic [3:0][31:0] wdata;
        logic [3:0][31:0] addr;
        logic [3:0][31:0] rdata;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_we;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_init;

    always #5 clk = ~clk;

    vector_lsu_if #(.LANES(L), .WORD_W(32)) bus ();

    vector_lsu #(.LANES(L), .WORD_W(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .lsu         (bus),
        .mem_we      (mem_we),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    // Zero-wait memory; word index from address bits [11:2] keeps all test addresses distinct.
    logic [31:0] mem [1024];
    assign mem_rdata = mem[mem_address[11:2]];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int j = 0; j < 1024; j++) mem[j] <= '0;
            for (int j = 0; j < 4; j++) mem[10'h040 + j] <= 32'hA0 + j;
            mem[10'h3FE] <= 32'hB0;
            mem[10'h3FF] <= 32'hB1;
            mem[10'h000] <= 32'hB2;
            mem[10'h001] <= 32'hB3;
            mem[10'h004] <= 32'hC0;
            mem[10'h003] <= 32'hC1;
            mem[10'h002] <= 32'hC2;
        end else if (mem_we) begin
            mem[mem_address[11:2]] <= mem_wdata;
        end
    end

    int unsigned cycle      = 0;
    int unsigned wr_count   = 0;
    int unsigned resp_count = 0;
    int unsigned accepts[$];

    always @(posedge clk) begin
        cycle <= cycle + 1;
        if (mem_we) wr_count <= wr_count + 1;
        if (bus.resp_valid) resp_count <= resp_count + 1;
        if (bus.req_valid && bus.req_ready && !reset) accepts.push_back(cycle);
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_req(input logic st, input logic [31:0] base, input logic [15:0] stride,
                             input logic [127:0] wdata);
        bus.req_store  = st;
        bus.req_base   = base;
        bus.req_stride = stride;
        bus.req_wdata  = wdata;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        @(posedge clk); #1;
        drive_req(v.store, v.base, v.stride, v.wdata);
        bus.req_valid = 1'b1;
        @(negedge clk);
        check($sformatf("v%0d ready_pre", idx), 128'(bus.req_ready), 128'd1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        for (int i = 0; i < L; i++) begin
            @(negedge clk);
            check($sformatf("v%0d addr%0d", idx, i), 128'(mem_address), 128'(v.addr[i]));
            check($sformatf("v%0d we%0d", idx, i), 128'(mem_we), 128'(v.store));
            check($sformatf("v%0d rv%0d", idx, i), 128'(bus.resp_valid), 128'd0);
            if (v.store)
                check($sformatf("v%0d wd%0d", idx, i), 128'(mem_wdata), 128'(v.wdata[i]));
        end
        @(negedge clk);
        check($sformatf("v%0d resp_valid", idx), 128'(bus.resp_valid), 128'd1);
        check($sformatf("v%0d rdata", idx), bus.resp_rdata, v.rdata);
        check($sformatf("v%0d done_addr", idx), 128'(mem_address), 128'd0);
        @(negedge clk);
        check($sformatf("v%0d ready_post", idx), 128'(bus.req_ready), 128'd1);
        check($sformatf("v%0d rv_post", idx), 128'(bus.resp_valid), 128'd0);
        $display("[TB] vec %0d store=%0d base=%h stride=%0d rdata=%h", idx, v.store, v.base,
                 $signed(v.stride), bus.resp_rdata);
    endtask

    vec_t vecs[7];
    int unsigned w0;
    int unsigned r0;

    initial begin
        vecs[0] = '{store: 1'b0, base: 32'h100, stride: 16'd1, wdata: '0,
                    addr:  {32'h10C, 32'h108, 32'h104, 32'h100},
                    rdata: {32'hA3, 32'hA2, 32'hA1, 32'hA0}};
        vecs[1] = '{store: 1'b1, base: 32'h200, stride: 16'd2,
                    wdata: {32'h44, 32'h33, 32'h22, 32'h11},
                    addr:  {32'h218, 32'h210, 32'h208, 32'h200},
                    rdata: {32'hA3, 32'hA2, 32'hA1, 32'hA0}};
        vecs[2] = '{store: 1'b0, base: 32'h200, stride: 16'd2, wdata: '0,
                    addr:  {32'h218, 32'h210, 32'h208, 32'h200},
                    rdata: {32'h44, 32'h33, 32'h22, 32'h11}};
        vecs[3] = '{store: 1'b0, base: 32'hFFFF_FFF8, stride: 16'd1, wdata: '0,
                    addr:  {32'h4, 32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFF8},
                    rdata: {32'hB3, 32'hB2, 32'hB1, 32'hB0}};
        vecs[4] = '{store: 1'b0, base: 32'h10, stride: 16'hFFFF, wdata: '0,
                    addr:  {32'h4, 32'h8, 32'hC, 32'h10},
                    rdata: {32'hB3, 32'hC2, 32'hC1, 32'hC0}};
        vecs[5] = '{store: 1'b1, base: 32'h103, stride: 16'd0,
                    wdata: {32'h8, 32'h7, 32'h6, 32'h5},
                    addr:  {32'h100, 32'h100, 32'h100, 32'h100},
                    rdata: {32'hB3, 32'hC2, 32'hC1, 32'hC0}};
        vecs[6] = '{store: 1'b0, base: 32'h100, stride: 16'd0, wdata: '0,
                    addr:  {32'h100, 32'h100, 32'h100, 32'h100},
                    rdata: {32'h8, 32'h8, 32'h8, 32'h8}};

        // Reset with a simultaneous request: reset must win.
        mem_init      = 1'b1;
        reset         = 1'b1;
        bus.req_valid = 1'b1;
        drive_req(1'b1, 32'h400, 16'd1, {4{32'hFFFF_FFFF}});
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst ready", 128'(bus.req_ready), 128'd1);
        check("rst busy", 128'(bus.busy), 128'd0);
        check("rst resp_valid", 128'(bus.resp_valid), 128'd0);
        check("rst we", 128'(mem_we), 128'd0);
        check("rst addr", 128'(mem_address), 128'd0);
        check("rst wdata", 128'(mem_wdata), 128'd0);
        check("rst rdata", bus.resp_rdata, 128'd0);
        $display("[TB] reset state ready=%0d busy=%0d", bus.req_ready, bus.busy);
        bus.req_valid = 1'b0;
        mem_init      = 1'b0;
        reset         = 1'b0;

        for (int v = 0; v < 7; v++) begin
            run_vec(vecs[v], v);
            if (v == 1) begin
                check("st mem 0x200", 128'(mem[10'h080]), 128'h11);
                check("st mem 0x218", 128'(mem[10'h086]), 128'h44);
            end
            if (v == 5) check("zs mem 0x100", 128'(mem[10'h040]), 128'h8);
        end

        // Reset during the 2nd ACCESS cycle of a store aborts it after two writes.
        w0 = wr_count;
        r0 = resp_count;
        @(posedge clk); #1;
        drive_req(1'b1, 32'h300, 16'd1, {32'h4, 32'h3, 32'h2, 32'h1});
        bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort ready", 128'(bus.req_ready), 128'd1);
        check("abort we", 128'(mem_we), 128'd0);
        check("abort rdata", bus.resp_rdata, 128'd0);
        repeat (6) @(negedge clk);
        check("abort writes", 128'(wr_count - w0), 128'd2);
        check("abort resp", 128'(resp_count - r0), 128'd0);
        check("abort mem0", 128'(mem[10'h0C0]), 128'h1);
        check("abort mem1", 128'(mem[10'h0C1]), 128'h2);
        check("abort mem2", 128'(mem[10'h0C2]), 128'h0);
        $display("[TB] abort writes=%0d resp=%0d", wr_count - w0, resp_count - r0);

        // req_valid held for 10 edges: accepts only at k and k+6.
        accepts.delete();
        w0 = wr_count;
        @(posedge clk); #1;
        drive_req(1'b0, 32'h100, 16'd1, '0);
        bus.req_valid = 1'b1;
        for (int e = 0; e < 10; e++) begin
            @(posedge clk); #1;
            if (e == 2) drive_req(1'b1, 32'h500, 16'd1, {4{32'hDEAD_BEEF}});
            if (e == 3) drive_req(1'b0, 32'h200, 16'd2, '0);
        end
        bus.req_valid = 1'b0;
        repeat (8) @(negedge clk);
        check("busy accepts", 128'(accepts.size()), 128'd2);
        check("busy gap", (accepts.size() >= 2) ? 128'(accepts[1] - accepts[0]) : 128'd0, 128'd6);
        check("busy writes", 128'(wr_count - w0), 128'd0);
        check("busy mem 0x500", 128'(mem[10'h140]), 128'h0);
        check("busy rdata", bus.resp_rdata, {32'h44, 32'h33, 32'h22, 32'h11});
        $display("[TB] busy-ignore accepts=%0d rdata=%h", accepts.size(), bus.resp_rdata);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vector_lsu.md
VECTOR_LSU -- requirements
Module: vector_lsu

Interface
REQ-001 The block SHALL have parameter LANES, default 4, giving the number of 32-bit lanes per vector transfer.
REQ-002 The block SHALL have parameter WORD_W, default 32, giving the data width of the memory port and of each lane.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port req_valid, input, 1 bit: a vector request is presented.
REQ-006 The block SHALL have port req_ready, output, 1 bit: the block can accept a request.
REQ-007 The block SHALL have port req_store, input, 1 bit: 1 = store vector, 0 = load vector.
REQ-008 The block SHALL have port req_base, input, 32 bits: byte base address.
REQ-009 The block SHALL have port req_stride, input, 16 bits: signed stride, in words.
REQ-010 The block SHALL have port req_wdata, input, LANES*WORD_W bits: store data, lane i at bits [i*WORD_W +: WORD_W].
REQ-011 The block SHALL have port resp_valid, output, 1 bit: one-cycle completion pulse.
REQ-012 The block SHALL have port resp_rdata, output, LANES*WORD_W bits: load result, same lane packing as req_wdata.
REQ-013 The block SHALL have port busy, output, 1 bit: a transfer is in progress.
REQ-014 The block SHALL have port mem_we, output, 1 bit: write enable to the data memory.
REQ-015 The block SHALL have port mem_address, output, 32 bits: byte address to the data memory.
REQ-016 The block SHALL have port mem_wdata, output, WORD_W bits: write data to the data memory.
REQ-017 The block SHALL have port mem_rdata, input, WORD_W bits: combinational read data from the data memory.

Function
REQ-018 The FSM SHALL have exactly three states, IDLE, ACCESS and DONE; req_ready SHALL be 1 only in IDLE, and busy SHALL be 1 in ACCESS and DONE.
REQ-019 A request SHALL be accepted on the edge where req_valid && req_ready; the block SHALL latch req_store, req_base, req_stride and req_wdata, clear the lane counter to 0, and go to ACCESS.
REQ-020 In ACCESS, lane i's address SHALL be req_base + i*stride*4, computed as a running 32-bit accumulator that wraps modulo 2^32.
REQ-021 mem_address SHALL present the accumulator with bits [1:0] forced to 0, so unaligned base bits are ignored.
REQ-022 A stride of 0 SHALL repeat the same address for every lane, and a negative stride SHALL give descending addresses.
REQ-023 For a store, mem_we SHALL be 1 and mem_wdata SHALL carry lane i in every ACCESS cycle.
REQ-024 For a load, mem_we SHALL be 0, and mem_rdata SHALL be captured into lane i of resp_rdata at the end of that ACCESS cycle (zero-wait memory).
REQ-025 ACCESS SHALL last exactly LANES cycles; after lane LANES-1 the FSM SHALL go to DONE.
REQ-026 DONE SHALL last one cycle with resp_valid=1, after which the FSM SHALL return to IDLE.
REQ-027 For a request accepted at edge k, memory accesses SHALL occur in cycles k+1..k+LANES, resp_valid SHALL be high in cycle k+LANES+1, and req_ready SHALL be high again from cycle k+LANES+2.
REQ-028 resp_rdata SHALL hold its value until the next load overwrites it; a store SHALL not modify resp_rdata.
REQ-029 Outside ACCESS, mem_we, mem_address and mem_wdata SHALL be 0.
REQ-030 req_valid and request fields SHALL be ignored while busy, and requests SHALL never be queued.

Reset
REQ-031 While reset is sampled high, the FSM SHALL go to IDLE, and req_ready SHALL be 1 while busy, resp_valid, mem_we, mem_address, mem_wdata and resp_rdata SHALL all be 0 from the following cycle.
REQ-032 A reset during ACCESS SHALL abort the transfer with no resp_valid pulse; memory writes already issued SHALL stand, and no further mem_we SHALL be asserted.
REQ-033 reset SHALL take priority over a simultaneous req_valid.

Structure
REQ-034 Package vlsu_pkg SHALL hold WORD_W, the default LANES, and the state enum type vlsu_state_t (IDLE, ACCESS, DONE).
REQ-035 A sub-module vlsu_agu SHALL hold the address accumulator, the lane counter and the last-lane flag; the data path and FSM SHALL stay in vector_lsu.

Verification
REQ-036 Load test: memory word m[i] = 0xA0+i, base 0x100, stride 1, load -> addresses 0x100, 0x104, 0x108, 0x10C, resp_rdata lanes {0xA3, 0xA2, 0xA1, 0xA0} (lane 0 in the low bits), resp_valid in cycle k+5.
REQ-037 Store test: base 0x200, stride 2, wdata lanes 0x11, 0x22, 0x33, 0x44 -> mem_we for 4 cycles at 0x200, 0x208, 0x210, 0x218; a reload of the same addresses returns the same data.
REQ-038 Wrap and negative-stride test: base 0xFFFFFFF8, stride 1 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4; base 0x10, stride -1 -> 0x10, 0xC, 0x8, 0x4.
REQ-039 Unaligned and zero-stride test: base 0x103, stride 0, store -> all four writes at 0x100, and the final memory word holds lane 3.
REQ-040 Reset test: reset asserted in the 2nd ACCESS cycle of a store -> exactly 2 writes, no resp_valid, req_ready=1 next cycle.
REQ-041 Busy-ignore test: req_valid held high for 10 cycles -> requests accepted only at edges k and k+6; the field values present at edge k+3 have no effect.
